// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-2 multiply/divide control sequencer:
// state encodings, opcodes and the control-bundle field order.
package cpu_pkg;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam int         CNT_W_DEF = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_ILL
  } state_e;

  // Field order matches the datapath control inputs, MSB first.
  typedef struct packed {
    logic pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in;
    logic gra, grb, r_out, ry_in;
    logic mul_sel, div_sel;
    logic rz_in_lo, rz_in_hi, rz_out_lo, rz_out_hi, lo_in, hi_in;
    logic run, illegal;
  } ctrl_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_control.sv
// Moore sequencer stepping fetch -> decode -> Y -> Z{Hi,Lo} -> LO/HI for mul/div,
// one control step per clock; outputs are a pure decode of the state register.
module mul_div_control
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             mem_ready,
  input  logic [4:0]       ir_op,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             MDRread,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Rout,
  output logic             RYin,
  output logic             MULsel,
  output logic             DIVsel,
  output logic             RZinLo,
  output logic             RZinHi,
  output logic             RZoutLo,
  output logic             RZoutHi,
  output logic             LOin,
  output logic             HIin,
  output logic             Run,
  output logic             Illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e     state, state_nxt;
  logic [4:0] op_reg;
  ctrl_t      c;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      op_reg    <= OP_MUL;
      instr_cnt <= '0;
    end else begin
      state <= state_nxt;
      // IR loads on this same edge, so capture the opcode straight off the bus
      if (state == S_T2) op_reg <= ir_op;
      if (state == S_T7) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
      S_T2:   state_nxt = is_muldiv(ir_op) ? S_T3 : S_ILL;
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = S_T6;
      S_T6:   state_nxt = S_T7;
      S_T7,
      S_ILL:  state_nxt = stop ? S_IDLE : S_T0;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    c     = '0;
    c.run = (state != S_IDLE);
    case (state)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.rz_in_lo = 1'b1;
      end
      S_T1: begin c.mdr_read = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.ry_in = 1'b1; end
      S_T4: begin
        c.grb = 1'b1; c.r_out = 1'b1;
        c.mul_sel = (op_reg == OP_MUL); c.div_sel = (op_reg == OP_DIV);
      end
      S_T5: begin
        c.rz_in_lo = 1'b1; c.rz_in_hi = 1'b1;
        c.mul_sel = (op_reg == OP_MUL); c.div_sel = (op_reg == OP_DIV);
      end
      S_T6:  begin c.rz_out_lo = 1'b1; c.lo_in = 1'b1; end
      S_T7:  begin c.rz_out_hi = 1'b1; c.hi_in = 1'b1; end
      S_ILL: c.illegal = 1'b1;
      default: ;
    endcase
  end

  assign PCout   = c.pc_out;
  assign MARin   = c.mar_in;
  assign IncPC   = c.inc_pc;
  assign MDRread = c.mdr_read;
  assign MDRin   = c.mdr_in;
  assign MDRout  = c.mdr_out;
  assign IRin    = c.ir_in;
  assign Gra     = c.gra;
  assign Grb     = c.grb;
  assign Rout    = c.r_out;
  assign RYin    = c.ry_in;
  assign MULsel  = c.mul_sel;
  assign DIVsel  = c.div_sel;
  assign RZinLo  = c.rz_in_lo;
  assign RZinHi  = c.rz_in_hi;
  assign RZoutLo = c.rz_out_lo;
  assign RZoutHi = c.rz_out_hi;
  assign LOin    = c.lo_in;
  assign HIin    = c.hi_in;
  assign Run     = c.run;
  assign Illegal = c.illegal;

endmodule
